// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared types and constants for the game-flow controller.
// Holds the FSM state enum, screen-mode codes, default keycodes and
// small width/decode helpers used by the interface and the top.
package game_flow_pkg;

    typedef enum logic [3:0] {
        ST_RES   = 4'd0,
        ST_LOAD  = 4'd1,
        ST_PLAY  = 4'd2,
        ST_PAUSE = 4'd3,
        ST_DYING = 4'd4,
        ST_SPAWN = 4'd5,
        ST_CLEAR = 4'd6,
        ST_OVER  = 4'd7,
        ST_WIN   = 4'd8
    } game_state_t;

    localparam logic [2:0] SCR_PLAY  = 3'd0;
    localparam logic [2:0] SCR_PAUSE = 3'd1;
    localparam logic [2:0] SCR_OVER  = 3'd2;
    localparam logic [2:0] SCR_WIN   = 3'd3;
    localparam logic [2:0] SCR_DYING = 3'd4;
    localparam logic [2:0] SCR_CLEAR = 3'd5;
    localparam logic [2:0] SCR_LOAD  = 3'd6;

    localparam logic [7:0] KEY_ENTER_DEF = 8'h28;
    localparam logic [7:0] KEY_PAUSE_DEF = 8'h13;

    // Level index width, never narrower than one bit.
    function automatic int lvl_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold 0..n lives.
    function automatic int life_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Screen mode shown for each state; SPAWN keeps the play screen up.
    function automatic logic [2:0] scr_of(input game_state_t s);
        logic [2:0] r;
        case (s)
            ST_PLAY, ST_SPAWN: r = SCR_PLAY;
            ST_PAUSE:          r = SCR_PAUSE;
            ST_DYING:          r = SCR_DYING;
            ST_CLEAR:          r = SCR_CLEAR;
            ST_OVER:           r = SCR_OVER;
            ST_WIN:            r = SCR_WIN;
            default:           r = SCR_LOAD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: bundles the controller's game-side inputs and its
// playfield/actor-facing outputs. The master modport is the controller.
interface game_flow_ctrl_if #(
    parameter int NUM_LEVELS = 3,
    parameter int NUM_LIVES  = 3
);
    import game_flow_pkg::*;

    localparam int LVL_W  = lvl_w(NUM_LEVELS);
    localparam int LIFE_W = life_w(NUM_LIVES);

    // Signal semantics: there is no valid/ready backpressure on this bundle.
    // frame_tick is a one-cycle strobe per frame; over/win are level inputs
    // sampled on every rising edge while in PLAY; keycode is sampled every
    // edge. Every output is a register that is valid every cycle.
    logic [7:0]        keycode;
    logic              frame_tick;
    logic              over;
    logic              win;
    logic              reseton;
    logic              respawn;
    logic [LVL_W-1:0]  level;
    logic [LIFE_W-1:0] lives;
    logic [2:0]        screen;
    game_state_t       state;

    modport master (
        input  keycode, frame_tick, over, win,
        output reseton, respawn, level, lives, screen, state
    );

    modport slave (
        output keycode, frame_tick, over, win,
        input  reseton, respawn, level, lives, screen, state
    );

endinterface

// File: rtl/game_flow_ctrl_key_edge.sv
// key_edge: one-shot detector for a single keycode. A hit fires in the
// first cycle the keycode matches KEY after a cycle where it did not.
module key_edge
    import game_flow_pkg::*;
#(
    parameter logic [7:0] KEY = KEY_ENTER_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       hit
);

    logic [7:0] prev_q;

    // Remember last cycle's keycode for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) prev_q <= 8'h00;
        else       prev_q <= keycode;
    end

    assign hit = (keycode == KEY) && (prev_q != KEY);

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: multi-level game-flow FSM with lives, timed death and
// level-clear holds, and keyboard restart. Optional pause is built when
// the macro GAME_PAUSE_EN is defined. All outputs are registered from the
// next-state decode so they always match the current state.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int         NUM_LEVELS  = 3,
    parameter int         NUM_LIVES   = 3,
    parameter int         HOLD_FRAMES = 60,
    parameter logic [7:0] KEY_ENTER   = KEY_ENTER_DEF,
    parameter logic [7:0] KEY_PAUSE   = KEY_PAUSE_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    game_flow_ctrl_if.master bus
);

    localparam int LVL_W  = lvl_w(NUM_LEVELS);
    localparam int LIFE_W = life_w(NUM_LIVES);
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_FRAMES);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(NUM_LIVES);
    localparam logic [LVL_W-1:0]  LVL_LAST   = LVL_W'(NUM_LEVELS - 1);

    game_state_t       state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              reseton_q, respawn_q;
    logic [2:0]        screen_q;
    logic              enter_hit, pause_hit;

    key_edge #(.KEY(KEY_ENTER)) u_enter (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (bus.keycode),
        .hit     (enter_hit)
    );

`ifdef GAME_PAUSE_EN
    key_edge #(.KEY(KEY_PAUSE)) u_pause (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (bus.keycode),
        .hit     (pause_hit)
    );
`else
    // Pause is tied off; the compare keeps KEY_PAUSE referenced so both
    // builds share one parameter list.
    assign pause_hit = (bus.keycode == KEY_PAUSE) & 1'b0;
`endif

    // Next-state and datapath decode; over/win only matter in PLAY.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        case (state_q)
            ST_RES:   state_d = ST_PLAY;
            ST_LOAD:  state_d = ST_PLAY;
            ST_SPAWN: state_d = ST_PLAY;
            ST_PLAY: begin
                if (bus.over) begin
                    state_d = ST_DYING;
                    lives_d = lives_q - LIFE_W'(1);
                    hold_d  = '0;
                end else if (bus.win) begin
                    state_d = ST_CLEAR;
                    hold_d  = '0;
                end else if (pause_hit) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_hit) state_d = ST_PLAY;
            end
            ST_DYING: begin
                if (hold_q == HOLD_MAX)
                    state_d = (lives_q == '0) ? ST_OVER : ST_SPAWN;
                else if (bus.frame_tick)
                    hold_d = hold_q + HOLD_W'(1);
            end
            ST_CLEAR: begin
                if (hold_q == HOLD_MAX) begin
                    if (level_q == LVL_LAST) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_LOAD;
                        level_d = level_q + LVL_W'(1);
                    end
                end else if (bus.frame_tick) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_OVER, ST_WIN: begin
                // Level and lives are restored on entry to RES so the
                // RES cycle already shows the fresh-game values.
                if (enter_hit) begin
                    state_d = ST_RES;
                    level_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: state_d = ST_RES;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_RES;
            level_q   <= '0;
            lives_q   <= LIVES_INIT;
            hold_q    <= '0;
            reseton_q <= 1'b1;
            respawn_q <= 1'b0;
            screen_q  <= SCR_LOAD;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            hold_q    <= hold_d;
            reseton_q <= (state_d == ST_RES) || (state_d == ST_LOAD);
            respawn_q <= (state_d == ST_SPAWN);
            screen_q  <= scr_of(state_d);
        end
    end

    assign bus.reseton = reseton_q;
    assign bus.respawn = respawn_q;
    assign bus.level   = level_q;
    assign bus.lives   = lives_q;
    assign bus.screen  = screen_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed stimulus with a scoreboard. Each driver step
// pushes the expected {reseton, respawn, level, lives, screen} after the
// edge; a monitor pops and compares on every falling edge.
// Build with or without GAME_PAUSE_EN; the pause section follows the macro.
module tb_game_flow_ctrl;
    import game_flow_pkg::*;

    localparam int W = 9;

    logic Clk;
    logic Reset;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(.HOLD_FRAMES(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [1:0]   e_lvl    = 2'd0;
    logic [1:0]   e_lives  = 2'd3;

    task automatic push_exp(input string nm, input logic rs, input logic rp,
                            input logic [2:0] scr);
        exp_q.push_back({rs, rp, e_lvl, e_lives, scr});
        name_q.push_back(nm);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    always @(negedge Clk) begin
        logic [W-1:0] exp_v, act_v;
        string        nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {bus.reseton, bus.respawn, bus.level, bus.lives, bus.screen};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL %s: got rs/rp/lvl/lives/scr=%b expected %b", nm, act_v, exp_v);
        end
    end

    // Driver: caller is just after a falling edge; apply inputs, clock once,
    // queue the expected outputs, then return at the next falling edge.
    task automatic step(input string nm, input logic [7:0] kc, input logic ft,
                        input logic ov, input logic wn, input logic rs,
                        input logic rp, input logic [2:0] scr);
        bus.keycode    = kc;
        bus.frame_tick = ft;
        bus.over       = ov;
        bus.win        = wn;
        @(posedge Clk);
        #1;
        push_exp(nm, rs, rp, scr);
        @(negedge Clk);
        #1;
    endtask

    // One death with HOLD_FRAMES=2, including idle cycles inside the hold.
    task automatic die_round(input bit last);
        e_lives = e_lives - 2'd1;
        step("over",      8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("hold_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("hold_t1",   8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("hold_gap",  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("hold_t2",   8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_DYING);
        if (!last) begin
            step("spawn",     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SCR_PLAY);
            step("back_play", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        end else begin
            step("game_over", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_OVER);
        end
    endtask

    // One level clear; non-final levels reload and advance.
    task automatic clear_round(input bit last);
        step("win",    8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SCR_CLEAR);
        step("clr_t1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SCR_CLEAR);
        step("clr_t2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_CLEAR);
        if (!last) begin
            e_lvl = e_lvl + 2'd1;
            step("load",      8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SCR_LOAD);
            step("load_play", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        end else begin
            step("game_win",  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_WIN);
        end
    endtask

    // Watchdog keeps the run bounded.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        Reset          = 1'b1;
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        bus.over       = 1'b0;
        bus.win        = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        push_exp("reset_vals", 1'b1, 1'b0, SCR_LOAD);
        @(negedge Clk);
        #1;
        Reset = 1'b0;

        // Single RES cycle, then PLAY.
        step("rel_play", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        step("idle",     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);

        // Three deaths: lives 2, 1, 0 then game over.
        die_round(1'b0);
        die_round(1'b0);
        die_round(1'b1);
        step("over_ign_win", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SCR_OVER);

        // Enter held 10 cycles: exactly one RES pulse.
        e_lvl   = 2'd0;
        e_lives = 2'd3;
        step("enter_res", 8'h28, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SCR_LOAD);
        for (int i = 0; i < 9; i++)
            step("enter_held", 8'h28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        step("enter_rel", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);

        // Level progression to WIN.
        clear_round(1'b0);
        clear_round(1'b0);
        clear_round(1'b1);
        step("win_ign_over", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SCR_WIN);
        e_lvl   = 2'd0;
        e_lives = 2'd3;
        step("win_enter", 8'h28, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, SCR_LOAD);
        step("win_play",  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);

        // over, win and pause key together: over takes priority.
        e_lives = 2'd2;
        step("over_win_p", 8'h13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SCR_DYING);
        step("ow_t1",      8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("ow_t2",      8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_DYING);
        step("ow_spawn",   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SCR_PLAY);
        step("ow_play",    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);

`ifdef GAME_PAUSE_EN
        step("pause_on",    8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PAUSE);
        step("pause_over",  8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SCR_PAUSE);
        step("pause_win",   8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SCR_PAUSE);
        step("pause_tick",  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PAUSE);
        step("pause_enter", 8'h28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PAUSE);
        step("pause_off",   8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
`else
        step("p_noeff", 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        step("p_held",  8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
        step("p_rel",   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);
`endif

        // Asynchronous reset mid-cycle while lives are 2.
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        bus.over       = 1'b0;
        bus.win        = 1'b0;
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        e_lvl   = 2'd0;
        e_lives = 2'd3;
        push_exp("async_rst", 1'b1, 1'b0, SCR_LOAD);
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        step("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SCR_PLAY);

        // Every queued expectation must have been consumed.
        @(negedge Clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller, successor to the single-level start/over/win FSM. Sequences multi-level play with a life counter, timed death and level-clear holds, edge-detected keyboard commands and optional pause. Sits between the USB keycode path, the collision/dot-count logic and the playfield and actor blocks. Drives playfield reload, actor respawn, current level, remaining lives and screen mode.

## Interface
- NUM_LEVELS, default 3: number of levels; level index runs 0..NUM_LEVELS-1.
- NUM_LIVES, default 3: lives at game start, must be >= 1.
- HOLD_FRAMES, default 60: frame_tick pulses spent in DYING and in CLEAR.
- KEY_ENTER, default 8'h28: restart keycode.
- KEY_PAUSE, default 8'h13: pause toggle keycode ('P').
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current keycode from the keyboard interface.
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived).
- over  in  1  player caught this cycle; sampled only in PLAY.
- win  in  1  all dots eaten on the current level; sampled only in PLAY.
- reseton  out  1  full playfield reload (dots and actors).
- respawn  out  1  actor reposition only, dots kept.
- level  out  LVL_W = $clog2(NUM_LEVELS) (min 1)  current level index.
- lives  out  LIFE_W = $clog2(NUM_LIVES+1)  remaining lives.
- screen  out  3  screen mode code, defined in the package.

## Operation
- States: RES, LOAD, PLAY, PAUSE, DYING, SPAWN, CLEAR, OVER, WIN.
- Key hit means keycode equals the key this cycle and differed last cycle. Holding a key produces exactly one hit.
- RES, one cycle: level <= 0, lives <= NUM_LIVES; then go to PLAY.
- LOAD, one cycle: level and lives unchanged; then go to PLAY.
- PLAY: priority is over > win > pause hit.
  - over: lives <= lives-1; go to DYING.
  - win: go to CLEAR.
  - pause hit: go to PAUSE.
- DYING: hold_cnt counts frame_tick pulses. When hold_cnt reaches HOLD_FRAMES:
  - lives == 0: go to OVER.
  - otherwise: go to SPAWN.
- SPAWN, one cycle: go to PLAY.
- CLEAR: same hold as DYING. Then:
  - level == NUM_LEVELS-1: go to WIN.
  - otherwise: level <= level+1 and go to LOAD.
- OVER / WIN: an Enter hit goes to RES. All other inputs are ignored.
- over and win are ignored in every state except PLAY.
- hold_cnt clears on entry to DYING and on entry to CLEAR.
- HOLD_FRAMES = 0: DYING and CLEAR exit on the cycle after entry.
- Outputs, all registered:
  - reseton = 1 while in RES or LOAD.
  - respawn = 1 while in SPAWN.
  - screen = code of the current state.

## Timing
- Reset values: state RES, reseton 1, respawn 0, level 0, lives NUM_LIVES, screen SCR_LOAD, hold_cnt 0, keycode history 0.
- After Reset deasserts: reseton stays high 1 cycle, then PLAY.
- over in cycle N:
  - screen = SCR_DYING and lives decremented from cycle N+1.
  - respawn high for exactly 1 cycle after the HOLD_FRAMES-th frame_tick.
- Enter hit in OVER/WIN in cycle N: reseton high in cycle N+1, PLAY in cycle N+2.
- over and win in the same cycle: over wins.
- over and a pause hit in the same cycle: over wins.
- An asynchronous Reset at any point forces the reset values immediately.

## Configuration
- GAME_PAUSE_EN defined:
  - Pause hit in PLAY goes to PAUSE; pause hit in PAUSE returns to PLAY.
  - PAUSE freezes hold_cnt and ignores over, win and Enter.
  - screen = SCR_PAUSE while paused.
- GAME_PAUSE_EN undefined:
  - PAUSE is unreachable; KEY_PAUSE is unused.
  - screen never equals SCR_PAUSE.

## Structure
- Package game_flow_pkg holds:
  - State enum game_state_t.
  - Screen codes: SCR_PLAY=0, SCR_PAUSE=1, SCR_OVER=2, SCR_WIN=3, SCR_DYING=4, SCR_CLEAR=5, SCR_LOAD=6.
  - Keycode constants KEY_ENTER_DEF and KEY_PAUSE_DEF.
- Sub-module key_edge: parameter KEY; ports Clk, Reset, keycode, hit.
  - Instantiated once for Enter and once for pause (the pause instance only under GAME_PAUSE_EN).

## Test plan
- Reset, then idle: reseton high 1 cycle, then screen=0, level=0, lives=3.
- Defaults, HOLD_FRAMES=2: over in three separate rounds.
  - lives goes 2, 1, 0.
  - respawn pulses after rounds 1 and 2.
  - screen=2 after the third DYING hold.
- win on levels 0 and 1: each gives a LOAD reseton pulse and level advances to 1, then 2. A third win gives screen=3 and level stays 2.
- over and win asserted in the same PLAY cycle: DYING is entered, lives decrements, level unchanged.
- In OVER, Enter held for 10 cycles: exactly one reseton pulse, then level=0 and lives=3.
- With GAME_PAUSE_EN: 'P' gives screen=1; over is ignored; frame_ticks do not advance the hold; a second 'P' returns to screen=0.
  - Without the macro, 'P' has no effect.
